mc_controller_p: RTL and testbench

- Next-generation multicycle MIPS control unit: a single Moore FSM plus an ALU decoder and PC-enable logic.
- Adds a memory ready/request handshake with wait states, an optional wait timeout, and BNE/ORI/ANDI/JAL support.
- Adds a sticky trap on illegal opcode/funct or memory timeout.
- Sits between the datapath (op, funct, zero) and the unified instruction/data memory.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_controller_p_aludec.sv | 43 ++++
 rtl/mc_controller_p.sv | 202 ++++++++++++++++++++
 tb/tb_mc_controller_p.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Contents: FSM state enum (5-bit encoding), opcode and funct constants,
// ALU operation codes, ALU decoder mode codes, and the datapath mux
// selector encodings for regdst / alusrcb / pcsrc.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMRD   = 5'd3,
    S_MEMWB   = 5'd4,
    S_MEMWR   = 5'd5,
    S_EXEC    = 5'd6,
    S_ALUWB   = 5'd7,
    S_BEQ     = 5'd8,
    S_BNE     = 5'd9,
    S_IMMEXEC = 5'd10,
    S_IMMWB   = 5'd11,
    S_JUMP    = 5'd12,
    S_JAL     = 5'd13,
    S_TRAP    = 5'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU decoder modes
  localparam logic [1:0] ALUM_ADD   = 2'b00;
  localparam logic [1:0] ALUM_SUB   = 2'b01;
  localparam logic [1:0] ALUM_FUNCT = 2'b10;
  localparam logic [1:0] ALUM_IMM   = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that talk to memory and therefore wait on mem_ready
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_controller_p_aludec.sv
// ALU decoder for the multicycle controller.
// Ports:
//   i_mode       ALU mode: add, sub, decode funct, or immediate op
//   i_funct      R-type funct field (or the funct-equivalent of an imm op)
//   o_alucontrol ALU operation, zero-padded above bit 2
//   o_illegal    funct not recognised (only meaningful in funct mode)
module aludec_p
  import mc_ctrl_pkg::*;
#(
  parameter int ALUC_W = 3
) (
  input  logic [1:0]        i_mode,
  input  logic [5:0]        i_funct,
  output logic [ALUC_W-1:0] o_alucontrol,
  output logic              o_illegal
);

  logic [2:0] w_op;

  always_comb begin
    w_op      = ALU_ADD;
    o_illegal = 1'b0;
    case (i_mode)
      ALUM_ADD: w_op = ALU_ADD;
      ALUM_SUB: w_op = ALU_SUB;
      default: begin
        // Immediate ops arrive translated to their R-type funct, so both
        // modes share one table.
        case (i_funct)
          FUNCT_ADD: w_op = ALU_ADD;
          FUNCT_SUB: w_op = ALU_SUB;
          FUNCT_AND: w_op = ALU_AND;
          FUNCT_OR:  w_op = ALU_OR;
          FUNCT_SLT: w_op = ALU_SLT;
          default:   o_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign o_alucontrol = ALUC_W'(w_op);

endmodule

// File: rtl/mc_controller_p.sv
// Multicycle MIPS control unit: Moore FSM with memory ready/request
// handshake, optional wait timeout, sticky trap, ALU decode and PC enable.
// Ports:
//   clk, reset (async, active-low)
//   op, funct, zero          datapath inputs
//   mem_ready / mem_req      memory handshake; memwrite qualifies mem_req
//   pcen, irwrite, regwrite  write enables
//   alusrca, alusrcb, iord, memtoreg, regdst, pcsrc, immext, linksel
//                            datapath mux selects
//   alucontrol               ALU operation
//   trap                     sticky error flag (illegal op/funct, timeout)
//   state_dbg                current state encoding
module mc_controller_p
  import mc_ctrl_pkg::*;
#(
  parameter int ALUC_W      = 3,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              pcen,
  output logic              memwrite,
  output logic              irwrite,
  output logic              regwrite,
  output logic              alusrca,
  output logic              iord,
  output logic              memtoreg,
  output logic [1:0]        regdst,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUC_W-1:0] alucontrol,
  output logic              immext,
  output logic              linksel,
  output logic              trap,
  output logic [4:0]        state_dbg
);

  localparam logic [CNT_W:0] TMO = (CNT_W+1)'(MEM_TIMEOUT);

  state_e           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_mem_state;
  logic             w_timeout;
  logic             w_imm_logic;
  logic             w_alu_illegal;
  logic [1:0]       w_alu_mode;
  logic [5:0]       w_alu_funct;

  assign w_mem_state = is_mem_state(r_state);
  assign w_cnt_inc   = {1'b0, r_wait_cnt} + (CNT_W+1)'(1);
  // The wait that would bring the count to MEM_TIMEOUT traps, unless
  // mem_ready shows up in that same cycle.
  assign w_timeout   = (MEM_TIMEOUT != 0) && !mem_ready && (w_cnt_inc == TMO);
  assign w_imm_logic = (op == OP_ANDI) || (op == OP_ORI);

  always_comb begin
    w_alu_mode  = ALUM_ADD;
    w_alu_funct = funct;
    case (r_state)
      S_EXEC:       w_alu_mode = ALUM_FUNCT;
      S_BEQ, S_BNE: w_alu_mode = ALUM_SUB;
      S_IMMEXEC: begin
        w_alu_mode  = ALUM_IMM;
        w_alu_funct = (op == OP_ANDI) ? FUNCT_AND :
                      (op == OP_ORI)  ? FUNCT_OR  : FUNCT_ADD;
      end
      default: ;
    endcase
  end

  aludec_p #(.ALUC_W(ALUC_W)) u_aludec (
    .i_mode       (w_alu_mode),
    .i_funct      (w_alu_funct),
    .o_alucontrol (alucontrol),
    .o_illegal    (w_alu_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      // Counts consecutive not-ready cycles of the current access; any
      // non-memory state or a completed access returns it to zero. With the
      // timeout disabled it may wrap, which is harmless.
      r_wait_cnt <= (w_mem_state && !mem_ready) ? w_cnt_inc[CNT_W-1:0] : '0;
      case (r_state)
        S_FETCH: begin
          if (mem_ready)      r_state <= S_DECODE;
          else if (w_timeout) r_state <= S_TRAP;
        end
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW:               r_state <= S_MEMADR;
            OP_RTYPE:                   r_state <= S_EXEC;
            OP_BEQ:                     r_state <= S_BEQ;
            OP_BNE:                     r_state <= S_BNE;
            OP_ADDI, OP_ANDI, OP_ORI:   r_state <= S_IMMEXEC;
            OP_J:                       r_state <= S_JUMP;
            OP_JAL:                     r_state <= S_JAL;
            default:                    r_state <= S_TRAP;
          endcase
        end
        S_MEMADR: r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (mem_ready)      r_state <= S_MEMWB;
          else if (w_timeout) r_state <= S_TRAP;
        end
        S_MEMWR: begin
          if (mem_ready)      r_state <= S_FETCH;
          else if (w_timeout) r_state <= S_TRAP;
        end
        S_EXEC:    r_state <= w_alu_illegal ? S_TRAP : S_ALUWB;
        S_IMMEXEC: r_state <= S_IMMWB;
        S_MEMWB, S_ALUWB, S_BEQ, S_BNE, S_IMMWB, S_JUMP, S_JAL:
                   r_state <= S_FETCH;
        default:   r_state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcen     = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    linksel  = 1'b0;
    regdst   = REGDST_RT;
    alusrcb  = SRCB_B;
    pcsrc    = PCSRC_ALU;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE: alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_EXEC: alusrca = 1'b1;
      S_ALUWB: begin
        regdst   = REGDST_RD;
        regwrite = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrca = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
        pcen    = (r_state == S_BEQ) ? zero : ~zero;
      end
      S_IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_IMMWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = PCSRC_JUMP;
        pcen  = 1'b1;
      end
      S_JAL: begin
        regdst   = REGDST_RA;
        linksel  = 1'b1;
        regwrite = 1'b1;
        pcsrc    = PCSRC_JUMP;
        pcen     = 1'b1;
      end
      default: ;
    endcase
  end

  // The zero-extend select must survive into the write-back cycle.
  assign immext    = w_imm_logic && ((r_state == S_IMMEXEC) || (r_state == S_IMMWB));
  assign trap      = (r_state == S_TRAP);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_mc_controller_p.sv
module tb_mc_controller_p;
  import mc_ctrl_pkg::*;

  localparam int TMO = 4;

  // Instruction fields, written independently of the package
  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
    T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000,
    T_ANDI = 6'b001100, T_ORI = 6'b001101, T_J = 6'b000010, T_JAL = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
    F_OR = 6'b100101, F_SLT = 6'b101010;

  typedef struct packed {
    logic [4:0] st;
    logic mem_req, memwrite, irwrite, pcen, regwrite, alusrca, iord, memtoreg;
    logic [1:0] regdst, alusrcb, pcsrc;
    logic [3:0] aluc;
    logic immext, linksel, trap;
  } obs_t;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg;
  logic [1:0] regdst, alusrcb, pcsrc;
  logic [3:0] alucontrol;
  logic immext, linksel, trap;
  logic [4:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  mc_controller_p #(.ALUC_W(4), .MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .pcen(pcen), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .immext(immext), .linksel(linksel), .trap(trap),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic bit funct_ok(input logic [5:0] f, output logic [3:0] a);
    case (f)
      F_ADD: begin a = 4'b0010; return 1'b1; end
      F_SUB: begin a = 4'b0110; return 1'b1; end
      F_AND: begin a = 4'b0000; return 1'b1; end
      F_OR:  begin a = 4'b0001; return 1'b1; end
      F_SLT: begin a = 4'b0111; return 1'b1; end
      default: begin a = 4'b0000; return 1'b0; end
    endcase
  endfunction

  // Required outputs for one cycle in a given state; c marks the fields the
  // description actually pins down in that state.
  function automatic void spec_out(input state_e s, input logic [5:0] o_p, f,
                                   input logic z, rdy, output obs_t e, output obs_t c);
    logic [3:0] a;
    bit ok;
    e = '0; c = '0;
    c.st = '1; c.mem_req = 1; c.memwrite = 1; c.irwrite = 1; c.pcen = 1;
    c.regwrite = 1; c.trap = 1;
    e.st = s;
    case (s)
      S_FETCH: begin
        e.mem_req = 1; e.irwrite = rdy; e.pcen = rdy;
        c.iord = 1; c.alusrca = 1; c.alusrcb = '1; e.alusrcb = 2'b01;
        c.aluc = '1; e.aluc = 4'b0010; c.pcsrc = '1;
      end
      S_DECODE: begin c.alusrcb = '1; e.alusrcb = 2'b11; c.aluc = '1; e.aluc = 4'b0010; end
      S_MEMADR: begin
        c.alusrca = 1; e.alusrca = 1; c.alusrcb = '1; e.alusrcb = 2'b10;
        c.aluc = '1; e.aluc = 4'b0010;
      end
      S_MEMRD: begin e.mem_req = 1; c.iord = 1; e.iord = 1; end
      S_MEMWR: begin e.mem_req = 1; e.memwrite = 1; c.iord = 1; e.iord = 1; end
      S_MEMWB: begin
        e.regwrite = 1; c.regdst = '1; c.memtoreg = 1; e.memtoreg = 1; c.linksel = 1;
      end
      S_EXEC: begin
        c.alusrca = 1; e.alusrca = 1; c.alusrcb = '1;
        ok = funct_ok(f, a);
        if (ok) begin c.aluc = '1; e.aluc = a; end
      end
      S_ALUWB: begin
        e.regwrite = 1; c.regdst = '1; e.regdst = 2'b01; c.memtoreg = 1; c.linksel = 1;
      end
      S_BEQ, S_BNE: begin
        c.alusrca = 1; e.alusrca = 1; c.alusrcb = '1; c.aluc = '1; e.aluc = 4'b0110;
        c.pcsrc = '1; e.pcsrc = 2'b01;
        e.pcen = (s == S_BEQ) ? z : ~z;
      end
      S_IMMEXEC: begin
        c.alusrca = 1; e.alusrca = 1; c.alusrcb = '1; e.alusrcb = 2'b10;
        c.aluc = '1;
        e.aluc = (o_p == T_ANDI) ? 4'b0000 : (o_p == T_ORI) ? 4'b0001 : 4'b0010;
        c.immext = 1; e.immext = (o_p == T_ANDI) || (o_p == T_ORI);
      end
      S_IMMWB: begin
        e.regwrite = 1; c.regdst = '1; c.memtoreg = 1; c.linksel = 1;
        c.immext = 1; e.immext = (o_p == T_ANDI) || (o_p == T_ORI);
      end
      S_JUMP: begin e.pcen = 1; c.pcsrc = '1; e.pcsrc = 2'b10; end
      S_JAL: begin
        e.pcen = 1; c.pcsrc = '1; e.pcsrc = 2'b10; e.regwrite = 1;
        c.regdst = '1; e.regdst = 2'b10; c.linksel = 1; e.linksel = 1; c.memtoreg = 1;
      end
      S_TRAP: e.trap = 1;
      default: ;
    endcase
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state_dbg; o.mem_req = mem_req; o.memwrite = memwrite; o.irwrite = irwrite;
    o.pcen = pcen; o.regwrite = regwrite; o.alusrca = alusrca; o.iord = iord;
    o.memtoreg = memtoreg; o.regdst = regdst; o.alusrcb = alusrcb; o.pcsrc = pcsrc;
    o.aluc = alucontrol; o.immext = immext; o.linksel = linksel; o.trap = trap;
    return o;
  endfunction

  // One observation: outputs of the current cycle against the expected state.
  task automatic check_now(input state_e s, input logic rdy, input string nm);
    obs_t e, c, o;
    spec_out(s, op, funct, zero, rdy, e, c);
    o = sample();
    n_checks++;
    if ((o & c) !== (e & c))
      $display("FAIL %s: observed %h required %h (expected state %0d, seen %0d) t=%0t",
               nm, o & c, e & c, s, state_dbg, $time);
    else
      n_pass++;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input state_e s, input logic rdy, input string nm);
    mem_ready = rdy;
    #1;
    check_now(s, rdy, nm);
    @(negedge clk);
  endtask

  // A memory access that waits w cycles; waits reaching TMO end in a trap.
  task automatic mem_phase(input state_e s, input int w, input string nm, output bit tr);
    tr = 1'b0;
    for (int i = 0; i < w && i < TMO; i++) step(s, 1'b0, nm);
    if (w >= TMO) tr = 1'b1;
    else step(s, 1'b1, nm);
  endtask

  task automatic run_instr(input logic [5:0] i_op, i_funct, input logic i_zero,
                           input int fw, mw, input string nm, output bit tr);
    logic [3:0] a;
    op = i_op; funct = i_funct; zero = i_zero;
    mem_phase(S_FETCH, fw, nm, tr);
    if (!tr) begin
      step(S_DECODE, 1'($urandom % 2), nm);
      case (i_op)
        T_LW: begin
          step(S_MEMADR, 1'($urandom % 2), nm);
          mem_phase(S_MEMRD, mw, nm, tr);
          if (!tr) step(S_MEMWB, 1'($urandom % 2), nm);
        end
        T_SW: begin
          step(S_MEMADR, 1'($urandom % 2), nm);
          mem_phase(S_MEMWR, mw, nm, tr);
        end
        T_R: begin
          step(S_EXEC, 1'($urandom % 2), nm);
          if (funct_ok(i_funct, a)) step(S_ALUWB, 1'($urandom % 2), nm);
          else tr = 1'b1;
        end
        T_BEQ: step(S_BEQ, 1'($urandom % 2), nm);
        T_BNE: step(S_BNE, 1'($urandom % 2), nm);
        T_ADDI, T_ANDI, T_ORI: begin
          step(S_IMMEXEC, 1'($urandom % 2), nm);
          step(S_IMMWB, 1'($urandom % 2), nm);
        end
        T_J:   step(S_JUMP, 1'($urandom % 2), nm);
        T_JAL: step(S_JAL, 1'($urandom % 2), nm);
        default: tr = 1'b1;
      endcase
    end
    if (tr) begin
      step(S_TRAP, 1'b1, nm);
      step(S_TRAP, 1'b0, nm);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(S_FETCH, 1'b0, "reset_hold");
    step(S_FETCH, 1'b0, "reset_hold2");
    reset = 1'b1;
    step(S_FETCH, 1'b0, "reset_release");
    do_reset();
  endtask

  task automatic test_rtype();
    bit tr;
    run_instr(T_R, F_SUB, 1'b0, 0, 0, "rtype_sub", tr);
    run_instr(T_R, F_SLT, 1'b1, 1, 0, "rtype_slt", tr);
    run_instr(T_R, F_OR, 1'b0, 2, 0, "rtype_or", tr);
  endtask

  task automatic test_lw_wait();
    bit tr;
    run_instr(T_LW, 6'h00, 1'b0, 0, 3, "lw_wait3", tr);
    run_instr(T_SW, 6'h00, 1'b0, 1, 2, "sw_wait2", tr);
  endtask

  task automatic test_branch();
    bit tr;
    run_instr(T_BNE, 6'h00, 1'b0, 0, 0, "bne_z0", tr);
    run_instr(T_BNE, 6'h00, 1'b1, 0, 0, "bne_z1", tr);
    run_instr(T_BEQ, 6'h00, 1'b0, 0, 0, "beq_z0", tr);
    run_instr(T_BEQ, 6'h00, 1'b1, 0, 0, "beq_z1", tr);
  endtask

  task automatic test_imm_jump();
    bit tr;
    run_instr(T_ORI,  6'h00, 1'b0, 0, 0, "ori", tr);
    run_instr(T_ANDI, 6'h00, 1'b0, 0, 0, "andi", tr);
    run_instr(T_ADDI, 6'h00, 1'b0, 0, 0, "addi", tr);
    run_instr(T_J,    6'h00, 1'b0, 0, 0, "jump", tr);
    run_instr(T_JAL,  6'h00, 1'b0, 0, 0, "jal", tr);
  endtask

  task automatic test_timeout();
    bit tr;
    run_instr(T_R, F_ADD, 1'b0, 10, 0, "fetch_timeout", tr);
    for (int i = 0; i < 3; i++) step(S_TRAP, 1'b1, "trap_sticky");
    do_reset();
    run_instr(T_LW, 6'h00, 1'b0, 0, TMO - 1, "lw_just_in_time", tr);
    run_instr(T_LW, 6'h00, 1'b0, 0, TMO, "lw_timeout", tr);
    do_reset();
    run_instr(T_SW, 6'h00, 1'b0, TMO - 1, TMO, "sw_timeout", tr);
    do_reset();
  endtask

  task automatic test_illegal();
    bit tr;
    run_instr(6'b111111, 6'h00, 1'b0, 0, 0, "illegal_op", tr);
    do_reset();
    run_instr(T_R, 6'b111111, 1'b0, 0, 0, "illegal_funct", tr);
    do_reset();
  endtask

  task automatic test_reset_mid_write();
    op = T_SW; funct = 6'h00; zero = 1'b0;
    step(S_FETCH, 1'b1, "rmw_fetch");
    step(S_DECODE, 1'b0, "rmw_decode");
    step(S_MEMADR, 1'b0, "rmw_memadr");
    step(S_MEMWR, 1'b0, "rmw_wait");
    mem_ready = 1'b0;
    #1 check_now(S_MEMWR, 1'b0, "rmw_before_reset");
    #1 reset = 1'b0;
    #1 check_now(S_FETCH, 1'b0, "rmw_async_reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit tr;
    logic [5:0] ops [11] = '{T_LW, T_SW, T_R, T_R, T_BEQ, T_BNE, T_ADDI, T_ANDI,
                             T_ORI, T_J, T_JAL};
    logic [5:0] fns [5] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    for (int n = 0; n < 150; n++) begin
      logic [5:0] o, f;
      int fw, mw;
      o  = ($urandom % 12 == 0) ? 6'($urandom) : ops[$urandom % 11];
      f  = ($urandom % 8 == 0) ? 6'($urandom) : fns[$urandom % 5];
      fw = ($urandom % 8 == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      mw = ($urandom % 8 == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      run_instr(o, f, 1'($urandom % 2), fw, mw, "random", tr);
      if (tr) do_reset();
    end
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; op = '0; funct = '0; zero = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_imm_jump();
    test_timeout();
    test_illegal();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
